// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the parallel-in serial-out transmitter.
// The master side supplies words and the bit strobe; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         bit_en;
    logic         sout;
    logic         sout_valid;
    logic         sof;
    logic         eof;
    logic         busy;

    modport master (
        output din, din_valid, bit_en,
        input  din_ready, sout, sout_valid, sof, eof, busy
    );

    modport slave (
        input  din, din_valid, bit_en,
        output din_ready, sout, sout_valid, sof, eof, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes an N-bit word on a valid/ready handshake
// and emits one bit per bit_en strobe, flagging the first and last bit of each frame.
module piso_serializer #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sout_q, sout_d;
    logic           sout_valid_q, sout_valid_d;
    logic           sof_q, sof_d;
    logic           eof_q, eof_d;
    logic           last_c;
    logic           ready_c;
    logic           accept_c;

    // The last emitting cycle doubles as an accept slot so frames can run back to back.
    assign last_c   = (state_q == SHIFT) && bus.bit_en && (cnt_q == CW'(N - 1));
    assign ready_c  = (state_q == IDLE) || last_c;
    assign accept_c = bus.din_valid && ready_c;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
        end
    end

    // Next-state, shift and output decode.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        sout_d       = IDLE_BIT;
        sout_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    sr_d    = bus.din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_en) begin
                    sout_d       = MSB_FIRST ? sr_q[N-1] : sr_q[0];
                    sout_valid_d = 1'b1;
                    sof_d        = (cnt_q == '0);
                    eof_d        = last_c;
                    sr_d         = MSB_FIRST ? {sr_q[N-2:0], 1'b0} : {1'b0, sr_q[N-1:1]};
                    cnt_d        = cnt_q + CW'(1);
                    if (last_c) begin
                        cnt_d = '0;
                        if (accept_c) begin
                            sr_d = bus.din;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.din_ready  = ready_c;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.sof        = sof_q;
    assign bus.eof        = eof_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a frame-level model checks every output each cycle, and the
// collected frames are compared against hand-computed words.
module tb_piso_serializer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    bit   chk_en;
    int   be_mode;
    int   cyc;

    piso_serializer_if #(.N(8)) b0 ();
    piso_serializer_if #(.N(8)) b1 ();

    piso_serializer #(.N(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );
    piso_serializer #(.N(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );

    localparam bit MSB_CFG [2]  = '{1'b1, 1'b0};
    localparam bit IDLE_CFG [2] = '{1'b0, 1'b1};

    // Model: the word in flight plus the index of the next bit to send.
    bit         m_act [2];
    logic [7:0] m_word [2];
    int         m_pos [2];
    logic       e_sout [2];
    logic       e_val [2];
    logic       e_sof [2];
    logic       e_eof [2];

    // Frame collector: bits shifted in as a receiver would see them.
    logic [7:0] cur [2];
    logic [7:0] frames0 [$];
    logic [7:0] frames1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic rst, input logic dv,
                              input logic be, input logic [7:0] d);
        bit ready;
        if (rst) begin
            m_act[i] = 1'b0;
            m_pos[i] = 0;
            e_sout[i] = IDLE_CFG[i];
            e_val[i] = 1'b0;
            e_sof[i] = 1'b0;
            e_eof[i] = 1'b0;
        end else begin
            ready = !m_act[i] || (be && m_pos[i] == 7);
            e_sout[i] = IDLE_CFG[i];
            e_val[i] = 1'b0;
            e_sof[i] = 1'b0;
            e_eof[i] = 1'b0;
            if (m_act[i] && be) begin
                e_sout[i] = MSB_CFG[i] ? m_word[i][7 - m_pos[i]] : m_word[i][m_pos[i]];
                e_val[i] = 1'b1;
                e_sof[i] = (m_pos[i] == 0);
                e_eof[i] = (m_pos[i] == 7);
                m_pos[i]++;
                if (m_pos[i] == 8) begin
                    m_act[i] = 1'b0;
                    m_pos[i] = 0;
                end
            end
            if (dv && ready) begin
                m_word[i] = d;
                m_pos[i] = 0;
                m_act[i] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, reset, b0.din_valid, b0.bit_en, b0.din);
        model_step(1, reset, b1.din_valid, b1.bit_en, b1.din);
    end

    task automatic check_inst(input int i, input logic so, input logic sv, input logic sf,
                              input logic ef, input logic bz, input logic rd, input logic be);
        chk($sformatf("u%0d sout", i), 32'(so), 32'(e_sout[i]));
        chk($sformatf("u%0d sout_valid", i), 32'(sv), 32'(e_val[i]));
        chk($sformatf("u%0d sof", i), 32'(sf), 32'(e_sof[i]));
        chk($sformatf("u%0d eof", i), 32'(ef), 32'(e_eof[i]));
        chk($sformatf("u%0d busy", i), 32'(bz), 32'(m_act[i]));
        chk($sformatf("u%0d din_ready", i), 32'(rd), 32'(!m_act[i] || (be && m_pos[i] == 7)));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, b0.sout, b0.sout_valid, b0.sof, b0.eof, b0.busy, b0.din_ready, b0.bit_en);
            check_inst(1, b1.sout, b1.sout_valid, b1.sof, b1.eof, b1.busy, b1.din_ready, b1.bit_en);
        end
        if (b0.sout_valid === 1'b1) begin
            cur[0] = b0.sof ? {7'd0, b0.sout} : {cur[0][6:0], b0.sout};
            if (b0.eof) frames0.push_back(cur[0]);
        end
        if (b1.sout_valid === 1'b1) begin
            cur[1] = b1.sof ? {7'd0, b1.sout} : {cur[1][6:0], b1.sout};
            if (b1.eof) frames1.push_back(cur[1]);
        end
    end

    // bit strobe for unit 0: constant high, or one pulse every 4 cycles
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            b0.bit_en = (be_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted, bounded by max_cyc cycles.
    task automatic send(input int i, input logic [7:0] w, input int max_cyc);
        bit r;
        bit done;
        done = 1'b0;
        if (i == 0) begin b0.din = w; b0.din_valid = 1'b1; end
        else        begin b1.din = w; b1.din_valid = 1'b1; end
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            r = (i == 0) ? b0.din_ready : b1.din_ready;
            @(posedge clk);
            #1;
            done = r;
        end
        if (i == 0) b0.din_valid = 1'b0;
        else        b1.din_valid = 1'b0;
        chk($sformatf("u%0d accept of %0h within %0d cycles", i, w, max_cyc), 32'(done), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        chk_en = 1'b0;
        be_mode = 0;
        reset = 1'b1;
        b0.din = '0; b0.din_valid = 1'b0; b0.bit_en = 1'b1;
        b1.din = '0; b1.din_valid = 1'b0; b1.bit_en = 1'b1;
        cycles(2);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("u0 busy after reset", 32'(b0.busy), 32'd0);
        chk("u0 din_ready after reset", 32'(b0.din_ready), 32'd1);
        chk("u1 idle level after reset", 32'(b1.sout), 32'd1);

        // 1: single frame, bit_en constant
        send(0, 8'hA5, 4);
        cycles(12);

        // 2: bit_en every 4th cycle
        be_mode = 1;
        send(0, 8'h3C, 4);
        cycles(40);
        be_mode = 0;
        cycles(2);

        // 3: back-to-back frames
        send(0, 8'hFF, 4);
        send(0, 8'h00, 20);
        cycles(12);

        // 4: backpressure during a frame
        send(0, 8'hA5, 4);
        cycles(2);
        chk("u0 ready low mid-frame", 32'(b0.din_ready), 32'd0);
        send(0, 8'h0F, 20);
        cycles(12);

        // 5: reset mid-frame, then a fresh frame
        send(0, 8'hA5, 4);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("u0 valid after mid reset", 32'(b0.sout_valid), 32'd0);
        chk("u0 busy after mid reset", 32'(b0.busy), 32'd0);
        cycles(2);
        send(0, 8'h81, 4);
        cycles(12);

        // 6: LSB-first unit with high idle level
        send(1, 8'h01, 4);
        cycles(12);
        chk("u1 idle level after frame", 32'(b1.sout), 32'd1);

        chk("u0 frame count", 32'(frames0.size()), 32'd7);
        if (frames0.size() == 7) begin
            chk("u0 frame A5", 32'(frames0[0]), 32'hA5);
            chk("u0 frame 3C", 32'(frames0[1]), 32'h3C);
            chk("u0 frame FF", 32'(frames0[2]), 32'hFF);
            chk("u0 frame 00", 32'(frames0[3]), 32'h00);
            chk("u0 frame A5 under backpressure", 32'(frames0[4]), 32'hA5);
            chk("u0 frame 0F", 32'(frames0[5]), 32'h0F);
            chk("u0 frame 81 after reset", 32'(frames0[6]), 32'h81);
        end
        chk("u1 frame count", 32'(frames1.size()), 32'd1);
        if (frames1.size() == 1) begin
            chk("u1 frame lsb-first 01", 32'(frames1[0]), 32'h80);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter. It accepts an N-bit word over a valid/ready handshake and emits it one bit per bit-enable strobe, with frame markers. It is the transmit-side counterpart of the serial-in shift registers and input filter in the shift-register library. It drives serial links whose receiver shifts bits into a parallel register.

Parameters:
N, 8, word width in bits (N >= 2)
MSB_FIRST, 1, 1: emit din[N-1] first; 0: emit din[0] first
IDLE_BIT, 0, level driven on sout in any cycle with no bit emitted

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  N  parallel word to transmit
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept din this cycle (combinational)
bit_en  input  1  bit-rate strobe; one bit is emitted per cycle in which bit_en=1 while shifting
sout  output  1  serial data (registered)
sout_valid  output  1  sout carries a frame bit this cycle (registered, 1-cycle pulse per bit)
sof  output  1  high with the first bit of a frame (registered)
eof  output  1  high with the last bit of a frame (registered)
busy  output  1  high while state=SHIFT

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high; it is sampled on the rising edge of clk.
- State: IDLE, SHIFT.
- Internal storage: shift register sr[N-1:0] and bit counter cnt, width clog2(N), range 0..N-1.
- Reset values: state=IDLE, sr=0, cnt=0, sout=IDLE_BIT, sout_valid=0, sof=0, eof=0. Therefore busy=0 and din_ready=1 in the first cycle after reset.
- din_ready = (state==IDLE) | (state==SHIFT & bit_en & cnt==N-1).
- Accept: an accept occurs on a rising edge where din_valid & din_ready. On accept: sr<=din, cnt<=0, state<=SHIFT.
- Accept is the only way to leave IDLE. bit_en is ignored in IDLE.
- Emit: in SHIFT, on a cycle with bit_en=1:
  - sout <= current bit: sr[N-1] if MSB_FIRST, else sr[0].
  - sout_valid<=1, sof<=(cnt==0), eof<=(cnt==N-1).
  - sr shifts by one toward the emitted end; the vacated bit is 0.
  - cnt<=cnt+1.
- Frame end: when cnt==N-1 and bit_en=1, the last bit is emitted.
  - If din_valid is also 1, the next word is accepted in the same cycle (reload, cnt<=0, stay SHIFT). This gives gap-free back-to-back frames.
  - Otherwise state<=IDLE and cnt<=0.
- Hold: in SHIFT with bit_en=0, sr, cnt and state hold. sout<=IDLE_BIT and sout_valid, sof and eof <=0.
- In IDLE: sout<=IDLE_BIT, sout_valid<=0, sof<=0, eof<=0.
- Latency:
  - Accept edge at cycle T. Bit-emitting edges follow at T+1 or later, one per bit_en=1 cycle. The first bit is visible on sout after the first such edge.
  - A bit_en asserted in the same cycle as an IDLE-state accept is not consumed.
  - With bit_en tied high, N consecutive bits appear after the accept edge.
- Backpressure: din_valid while SHIFT and not on the last emitting cycle gives din_ready=0 and no accept. The sender must hold din and din_valid stable until accepted.
- Reset mid-frame: the frame is discarded, with no eof. Outputs take reset values on the next edge, and the next accepted word starts a fresh frame with sof.
- reset has priority over accept and emit in the same cycle.
- Frame invariants:
  - Exactly N sout_valid pulses per accepted word, absent reset.
  - sof and eof each fire exactly once per frame and never outside sout_valid.
- No simultaneous sof and eof, since N >= 2.

Test Plan:
1. Defaults (N=8, MSB_FIRST=1), bit_en=1 constant, load 8'hA5 after reset → sout_valid high 8 consecutive cycles, sout=1,0,1,0,0,1,0,1, sof on bit 1 only, eof on bit 8 only, busy falls after eof, din_ready=1 in the IDLE cycle that follows.
2. bit_en pulsed once every 4 cycles, load 8'h3C → 8 isolated sout_valid pulses 4 cycles apart carrying 0,0,1,1,1,1,0,0; sout=0 (IDLE_BIT) and sof, eof low between pulses; busy high throughout.
3. Back-to-back: din_valid held high, 8'hFF then 8'h00, bit_en=1 → 16 contiguous sout_valid cycles (eight 1s then eight 0s), din_ready pulses in the cycle of the first eof, second sof immediately follows the first eof, no idle gap.
4. Backpressure: during 8'hA5 frame, present din=8'h0F with din_valid at bit 3 → din_ready=0 until bit 8, 8'hA5 bits unaltered, 8'h0F accepted on the eof cycle and transmitted next as 0,0,0,0,1,1,1,1.
5. Reset mid-frame: assert reset for 1 cycle after bit 3 of 8'hA5 → next cycle sout_valid=0, busy=0, sout=IDLE_BIT, no eof. A subsequent 8'h81 load emits a full 8-bit frame starting with sof, bits 1,0,0,0,0,0,0,1.
6. MSB_FIRST=0, IDLE_BIT=1, bit_en=1, load 8'h01 → sout=1,0,0,0,0,0,0,0 with sof on the first bit; sout=1 when idle before and after the frame.
